// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register/word widths, the zero register
// number and the writeback trace entry layout.
package pipeline_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;
  localparam int CYCLE_W    = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [WORD_W-1:0]     data;
    logic [WORD_W-1:0]     pc;
    logic [CYCLE_W-1:0]    cycle;
  } wb_trace_entry_t;

  localparam int ENTRY_W = $bits(wb_trace_entry_t);

endpackage

// File: rtl/wb_trace_mem.sv
// Trace entry storage: DEPTH x W register array, one synchronous write port
// and one asynchronous read port. Contents are not reset; the controller
// never presents a slot that has not been written since the last flush.
module wb_trace_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 32,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [W-1:0]     wr_data,
  input  logic [PTR_W-1:0] rd_ptr,
  output logic [W-1:0]     rd_data
);

  logic [W-1:0] mem_q [DEPTH];

  // Write the captured entry into the slot at the write pointer.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/wb_trace_fifo.sv
// Writeback trace FIFO: captures every committed non-$zero register write
// and hands it out over a valid/ready interface. Overflow drops are flagged
// (sticky) and counted (saturating at 255).
// Optional feature: define WB_TRACE_TIMESTAMP_EN to stamp each entry with a
// free-running 32-bit cycle counter presented on out_cycle.
module wb_trace_fifo
  import pipeline_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = WORD_W
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     wb_reg_write,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic [DATA_W-1:0]        wb_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [DATA_W-1:0]        out_data,
  output logic [DATA_W-1:0]        out_pc,
  output logic [31:0]              out_cycle,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef WB_TRACE_TIMESTAMP_EN
  localparam int MEM_W = ENTRY_W;
`else
  localparam int MEM_W = ENTRY_W - CYCLE_W;
`endif

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_count_q, drop_count_d;

  logic             push_req_s, pop_s, full_s, push_ok_s, drop_s;
  logic [MEM_W-1:0] wr_data_s, rd_data_s;
  wb_trace_entry_t  head_s;

  assign push_req_s = wb_reg_write && (wb_addr != REG_ZERO);
  assign full_s     = (count_q == CNT_W'(DEPTH));
  assign pop_s      = (count_q != '0) && out_ready;
  // When full, a push only fits if the head leaves on the same edge.
  assign push_ok_s  = push_req_s && (!full_s || pop_s);
  assign drop_s     = push_req_s && full_s && !pop_s;

`ifdef WB_TRACE_TIMESTAMP_EN
  logic [CYCLE_W-1:0] cycle_q, cycle_d;

  // Free-running timestamp: flushed by clear, wraps naturally at 2^32.
  always_comb begin
    cycle_d = cycle_q + 32'd1;
    if (clear) begin
      cycle_d = 32'd0;
    end else begin
      cycle_d = cycle_q + 32'd1;
    end
  end

  // Timestamp register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycle_q <= 32'd0;
    end else begin
      cycle_q <= cycle_d;
    end
  end

  assign wr_data_s = {wb_addr, wb_data, wb_pc, cycle_q};
  assign head_s    = rd_data_s;
`else
  assign wr_data_s = {wb_addr, wb_data, wb_pc};
  assign head_s    = {rd_data_s, 32'd0};
`endif

  wb_trace_mem #(
    .DEPTH (DEPTH),
    .W     (MEM_W)
  ) u_mem (
    .clock   (clock),
    .wr_en   (push_ok_s && !clear),
    .wr_ptr  (wr_ptr_q),
    .wr_data (wr_data_s),
    .rd_ptr  (rd_ptr_q),
    .rd_data (rd_data_s)
  );

  // Next-state for pointers, occupancy and drop bookkeeping; clear wins.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      overflow_d   = 1'b0;
      drop_count_d = 8'd0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_ok_s && !pop_s) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop_s && !push_ok_s) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        count_d = count_q;
      end
      if (drop_s) begin
        overflow_d = 1'b1;
        if (drop_count_q != 8'hFF) begin
          drop_count_d = drop_count_q + 8'd1;
        end else begin
          drop_count_d = drop_count_q;
        end
      end else begin
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Outputs come only from registered state; data fields are forced to 0
  // while empty so reset and flush present a clean zero head.
  assign out_valid  = (count_q != '0);
  assign out_addr   = out_valid ? head_s.addr  : '0;
  assign out_data   = out_valid ? head_s.data  : '0;
  assign out_pc     = out_valid ? head_s.pc    : '0;
  assign out_cycle  = out_valid ? head_s.cycle : 32'd0;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Scoreboard bench for wb_trace_fifo. Expected entries are queued when a
// capture is driven and compared when the DUT pops them. Honors
// WB_TRACE_TIMESTAMP_EN for the expected out_cycle value.
module tb_wb_trace_fifo;
  import pipeline_pkg::*;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        wb_reg_write = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic [31:0] wb_pc = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic [31:0] out_pc;
  logic [31:0] out_cycle;
  logic [3:0]  count;
  logic        overflow;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;
  wb_trace_entry_t sb[$];
  logic        exp_ovf = 1'b0;
  int          exp_drop = 0;
  logic [31:0] tb_cyc;

  wb_trace_fifo #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .clear(clear),
    .wb_reg_write(wb_reg_write), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc(wb_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_pc(out_pc), .out_cycle(out_cycle),
    .count(count), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  // Reference cycle counter: 0 out of reset/clear, +1 every edge otherwise.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) tb_cyc <= 32'd0;
    else if (clear) tb_cyc <= 32'd0;
    else tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check_val({tag, "_count"}, 32'(count), 32'(sb.size()));
    check_val({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    check_val({tag, "_drop"}, 32'(drop_count), 32'(exp_drop));
  endtask

  // One clock: drive inputs, check head before the edge, update model after.
  task automatic cycle(input logic we, input logic [4:0] a, input logic [31:0] d,
                       input logic [31:0] p, input logic rdy);
    logic pop;
    wb_trace_entry_t e, h;
    wb_reg_write = we; wb_addr = a; wb_data = d; wb_pc = p; out_ready = rdy; clear = 1'b0;
    #3;
    check_val("valid", 32'(out_valid), 32'(sb.size() != 0));
    pop = rdy && (sb.size() != 0);
    if (pop) begin
      h = sb[0];
      check_val("head_addr", 32'(out_addr), 32'(h.addr));
      check_val("head_data", out_data, h.data);
      check_val("head_pc", out_pc, h.pc);
      check_val("head_cycle", out_cycle, h.cycle);
    end
    e.addr = a; e.data = d; e.pc = p;
`ifdef WB_TRACE_TIMESTAMP_EN
    e.cycle = tb_cyc;
`else
    e.cycle = 32'd0;
`endif
    @(posedge clock);
    if (pop) h = sb.pop_front();
    if (we && a != 5'd0) begin
      if (sb.size() < DEPTH) sb.push_back(e);
      else begin
        exp_ovf = 1'b1;
        if (exp_drop < 255) exp_drop++;
      end
    end
    #1;
    check_state("cyc");
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 5'd0, 32'd0, 32'd0, rdy);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_valid"}, 32'(out_valid), 32'd0);
    check_val({tag, "_count"}, 32'(count), 32'd0);
    check_val({tag, "_ovf"}, 32'(overflow), 32'd0);
    check_val({tag, "_drop"}, 32'(drop_count), 32'd0);
    check_val({tag, "_addr"}, 32'(out_addr), 32'd0);
    check_val({tag, "_data"}, out_data, 32'd0);
    check_val({tag, "_pc"}, out_pc, 32'd0);
    check_val({tag, "_cycle"}, out_cycle, 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  initial begin
    // Reset and idle
    #2;
    check_zero_outputs("rst");
    release_reset();
    idle(1'b0);
    idle(1'b1);

    // Single capture, then drain
    cycle(1'b1, 5'd16, 32'h0000_0005, 32'h0000_0008, 1'b0);
    check_val("single_addr", 32'(out_addr), 32'd16);
    check_val("single_data", out_data, 32'h5);
    check_val("single_pc", out_pc, 32'h8);
    check_val("single_count", 32'(count), 32'd1);
    idle(1'b1);
    check_val("single_empty", 32'(out_valid), 32'd0);

    // Zero-register filter
    cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0000_0010, 1'b0);
    check_val("zero_count", 32'(count), 32'd0);

    // Overflow: 10 pushes into 8 slots
    for (int i = 0; i < 10; i++) cycle(1'b1, 5'(8 + i), 32'h100 + 32'(i), 32'h400 + 32'(4 * i), 1'b0);
    check_val("ovf_count", 32'(count), 32'd8);
    check_val("ovf_flag", 32'(overflow), 32'd1);
    check_val("ovf_drop", 32'(drop_count), 32'd2);

    // Full with simultaneous push and pop
    cycle(1'b1, 5'd19, 32'hABCD_0019, 32'h0000_0500, 1'b1);
    check_val("fullpp_count", 32'(count), 32'd8);
    check_val("fullpp_drop", 32'(drop_count), 32'd2);
    while (sb.size() > 1) idle(1'b1);
    check_val("last_addr", 32'(out_addr), 32'd19);
    idle(1'b1);
    idle(1'b1);  // pop attempt while empty

    // Clear beats a concurrent push and pop
    cycle(1'b1, 5'd3, 32'h33, 32'h44, 1'b0);
    cycle(1'b1, 5'd4, 32'h55, 32'h66, 1'b0);
    wb_reg_write = 1'b1; wb_addr = 5'd5; out_ready = 1'b1; clear = 1'b1;
    @(posedge clock);
    sb.delete(); exp_ovf = 1'b0; exp_drop = 0;
    #1;
    clear = 1'b0;
    check_state("clear");
    check_val("clear_valid", 32'(out_valid), 32'd0);

    // Timestamped pushes a few cycles apart, then streaming push+pop
    idle(1'b0);
    cycle(1'b1, 5'd9, 32'h9, 32'h90, 1'b0);
    idle(1'b0);
    idle(1'b0);
    cycle(1'b1, 5'd10, 32'hA, 32'hA0, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 5'(1 + i), $urandom, $urandom, 1'b1);
    while (sb.size() > 0) idle(1'b1);

    // Reset mid-drain with entries present
    for (int i = 0; i < 4; i++) cycle(1'b1, 5'(20 + i), 32'(i), 32'(i * 8), 1'b0);
    idle(1'b1);
    check_val("pre_rst_count", 32'(count), 32'd3);
    reset_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    sb.delete(); exp_ovf = 1'b0; exp_drop = 0;
    wb_reg_write = 1'b0; out_ready = 1'b0;
    release_reset();
    idle(1'b0);
    cycle(1'b1, 5'd31, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
    idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_trace_fifo.md
# wb_trace_fifo

Writeback trace buffer sitting directly downstream of the pipeline's WB stage. Every register-file write the pipeline commits (register number, data, PC of the committing instruction) is captured into a small FIFO and drained by a checker or bench through a valid/ready handshake. Benches can then compare committed architectural state against a golden model instead of sampling `$s0`–`$t3` each half-cycle. Writes to `$zero` are filtered; overflow is flagged and counted, never silently lost.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `ADDR_W`, 5: register number width.
- `DATA_W`, 32: register data and PC width.
- `clock` input 1: single clock; all state updates on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `clear` input 1: synchronous flush of entries, flags and counters.
- `wb_reg_write` input 1: WB-stage RegWrite; a capture request when high.
- `wb_addr` input ADDR_W: destination register number.
- `wb_data` input DATA_W: value written.
- `wb_pc` input DATA_W: PC of the committing instruction.
- `out_valid` output 1: head entry available.
- `out_ready` input 1: consumer accepts head entry.
- `out_addr` output ADDR_W: head register number.
- `out_data` output DATA_W: head data.
- `out_pc` output DATA_W: head PC.
- `out_cycle` output 32: head capture timestamp (see Configuration).
- `count` output $clog2(DEPTH)+1: current occupancy.
- `overflow` output 1: sticky; set when a capture was dropped.
- `drop_count` output 8: dropped captures, saturating at 255.

## Operation
- Push condition: `wb_reg_write && wb_addr != 0`. Writes to register 0 are ignored entirely (no push, no drop, no overflow).
- Pop condition: `out_valid && out_ready`.
- The push stores `{wb_addr, wb_data, wb_pc}` (plus timestamp if enabled) at the write pointer. The write pointer then advances modulo DEPTH.
- The pop advances the read pointer modulo DEPTH. Outputs always present the entry at the read pointer.
- Full (`count == DEPTH`), push, no pop: the capture is dropped. `overflow` is set and `drop_count` increments, saturating at 255.
- Full, push and pop in the same cycle: both are accepted; `count` stays at DEPTH; no drop.
- Empty, pop attempted: `out_valid` is low, so no effect.
- Push and pop when not full: `count` is unchanged; pointers both advance.
- `clear` takes priority over push and pop in the same cycle. It zeroes pointers, `count`, `overflow` and `drop_count`. Storage contents are don't-care.
- Reset (`reset_n` low, any time, including mid-drain): all outputs go to 0 immediately. This covers `out_valid`, `count`, `overflow`, `drop_count`, `out_addr`, `out_data`, `out_pc` and `out_cycle`. Pointers also go to 0.
- Out_* data fields read 0 whenever `count == 0`.

## Timing
- Latency is one cycle. A push at edge N gives `out_valid` high after edge N; there is no combinational fall-through.
- `out_valid` depends only on registered state. `out_ready` does not combinationally affect any output except through the next edge.
- Sustained throughput is one push and one pop per cycle.
- `count`, `overflow` and `drop_count` update on the same edge as the causing event.

## Configuration
- `WB_TRACE_TIMESTAMP_EN`
  - Defined: a free-running 32-bit cycle counter is built in. It resets to 0, is cleared by `clear`, and wraps at 2^32−1 → 0. Its value at the push edge is stored with each entry and presented on `out_cycle`.
  - Undefined: no counter and no timestamp storage; `out_cycle` is tied to 0.

## Structure
- Shared package `pipeline_pkg` holds:
  - `REG_ADDR_W=5` and `WORD_W=32`.
  - The `wb_trace_entry_t` packed struct `{addr, data, pc, cycle}`.
  - `REG_ZERO=5'd0`.
- One sub-module: `wb_trace_mem`, a DEPTH×entry register array with one write port and one asynchronous read port. Pointer, count and flag control stays in `wb_trace_fifo`.

## Test plan
- Reset and idle:
  - Assert `reset_n`=0 mid-operation with count=3 → all outputs 0 immediately.
  - After release with no pushes → `out_valid`=0, `count`=0.
- Single capture:
  - Push addr=16, data=0x00000005, pc=0x00000008, `out_ready`=0 → next cycle `out_valid`=1, `out_addr`=16, `out_data`=0x5, `out_pc`=0x8, `count`=1.
  - Then `out_ready`=1 for one cycle → `count`=0, `out_valid`=0.
- Zero filter: push addr=0, data=0xFFFFFFFF → `count` stays 0, `overflow`=0, `drop_count`=0.
- Overflow:
  - DEPTH=8, `out_ready`=0, 10 pushes of addrs 8..17 → `count`=8, `overflow`=1, `drop_count`=2.
  - Drain → addrs 8..15 come out in order.
- Full with simultaneous push/pop:
  - With the FIFO full, push addr=19 and pop in the same cycle → `count`=8, `drop_count` unchanged.
  - The last drained entry is addr=19.
- Timestamp (macro defined):
  - Pushes at cycles 4 and 7 after reset → `out_cycle` = 4, then 7.
  - Macro undefined → `out_cycle`=0 for both.
